// File: rtl/wb_ram_bist_master_pkg.sv
// Shared definitions for the Wishbone RAM BIST master.
//   bist_state_t : top-level FSM state encoding
//   SEL_ALL      : byte-select driven for every access (full 32-bit words)
//   bist_pat()   : test pattern for a word, seed XOR zero-extended word index
package wb_ram_bist_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_DONE   = 3'd5
    } bist_state_t;

    localparam logic [3:0] SEL_ALL = 4'hF;

    // Caller zero-extends the word index to 32 bits before calling.
    function automatic logic [31:0] bist_pat(input logic [31:0] seed,
                                             input logic [31:0] word);
        return seed ^ word;
    endfunction

endpackage

// File: rtl/wb_ram_bist_master_port.sv
// Single-access Wishbone classic initiator.
//   req / req_we / req_word / req_dat : access request, held level-high by the owner
//                                       until ack or timeout is seen
//   wb_*                              : Wishbone bus side (cyc/stb/we/sel/adr/dat out,
//                                       ack/dat in)
//   ack      : access completed this cycle (slave ack while strobing)
//   timeout  : access abandoned this cycle; owner must drop req next cycle
//   rdata    : slave read data, valid together with ack
// The bus outputs are a direct decode of req, so when req comes from a registered
// FSM state the bus drops within the same cycle as an asynchronous reset.
module wb_ram_bist_master_port
    import wb_ram_bist_master_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_word,
    input  logic [31:0]             req_dat,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [3:0]              wb_sel,
    output logic [ADDR_WIDTH+1:0]   wb_adr,
    output logic [31:0]             wb_dat_w,
    input  logic                    wb_ack,
    input  logic [31:0]             wb_dat_r,
    output logic                    ack,
    output logic                    timeout,
    output logic [31:0]             rdata
);

    // Abort fires in the cycle the counter would reach all-ones, giving
    // 2**TIMEOUT_WIDTH-1 strobe cycles without ack before cyc/stb drop.
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    logic [TIMEOUT_WIDTH-1:0] wait_cnt;

    assign wb_cyc   = req;
    assign wb_stb   = req;
    assign wb_we    = req & req_we;
    assign wb_sel   = req ? SEL_ALL : 4'h0;
    assign wb_adr   = req ? {req_word, 2'b00} : '0;
    assign wb_dat_w = (req && req_we) ? req_dat : 32'h0;

    // An ack arriving while not strobing is ignored here.
    assign ack     = req & wb_ack;
    assign timeout = req & ~wb_ack & (wait_cnt == TMO_LAST);
    assign rdata   = wb_dat_r;

    // Cleared whenever no access is pending (the mandatory gap cycle) so every
    // new request starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (!req || wb_ack)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule

// File: rtl/wb_ram_bist_master.sv
// Wishbone RAM BIST master: on start_i writes pat(w) to every word, then reads
// every word back and compares. Stops at the first mismatch or ack timeout.
//   wb_clk_i / wb_rst_n_i : clock, asynchronous active-low reset
//   start_i / seed_i      : launch pulse and pattern seed (ignored while busy_o)
//   wbm_*                 : Wishbone classic initiator port to the RAM
//   busy_o / done_o       : running / finished (done sticky until next start)
//   pass_o / timeout_o    : result flags, valid with done_o
//   fail_adr_o/fail_dat_o : word index and read data of the failing access
module wb_ram_bist_master
    import wb_ram_bist_master_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int TIMEOUT_WIDTH = 6
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic                    start_i,
    input  logic [31:0]             seed_i,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [3:0]              wbm_sel_o,
    output logic [ADDR_WIDTH+1:0]   wbm_adr_o,
    output logic [31:0]             wbm_dat_o,
    input  logic                    wbm_ack_i,
    input  logic [31:0]             wbm_dat_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [ADDR_WIDTH-1:0]   fail_adr_o,
    output logic [31:0]             fail_dat_o
);

    localparam logic [ADDR_WIDTH-1:0] WORD_LAST = '1;

    bist_state_t             state, state_nxt;
    logic [ADDR_WIDTH-1:0]   word;
    logic [31:0]             seed_q;
    logic [31:0]             pat;
    logic                    mis_q;

    logic                    port_req;
    logic                    port_we;
    logic                    port_ack;
    logic                    port_tmo;
    logic [31:0]             port_rdata;
    logic                    rd_mismatch;

    assign pat         = bist_pat(seed_q, 32'(word));
    assign port_req    = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    assign port_we     = (state == ST_WR_REQ);
    assign rd_mismatch = (state == ST_RD_REQ) && port_ack && (port_rdata != pat);

    wb_ram_bist_master_port #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_port (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .req      (port_req),
        .req_we   (port_we),
        .req_word (word),
        .req_dat  (pat),
        .wb_cyc   (wbm_cyc_o),
        .wb_stb   (wbm_stb_o),
        .wb_we    (wbm_we_o),
        .wb_sel   (wbm_sel_o),
        .wb_adr   (wbm_adr_o),
        .wb_dat_w (wbm_dat_o),
        .wb_ack   (wbm_ack_i),
        .wb_dat_r (wbm_dat_i),
        .ack      (port_ack),
        .timeout  (port_tmo),
        .rdata    (port_rdata)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_WR_REQ;
            ST_WR_REQ: begin
                if (port_tmo)      state_nxt = ST_DONE;
                else if (port_ack) state_nxt = ST_WR_GAP;
            end
            ST_WR_GAP: state_nxt = (word == WORD_LAST) ? ST_RD_REQ : ST_WR_REQ;
            ST_RD_REQ: begin
                // A failed compare ends the test without another access.
                if (port_tmo || rd_mismatch) state_nxt = ST_DONE;
                else if (port_ack)           state_nxt = ST_RD_GAP;
            end
            ST_RD_GAP: state_nxt = (word == WORD_LAST) ? ST_DONE : ST_RD_REQ;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            word       <= '0;
            seed_q     <= '0;
            mis_q      <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            timeout_o  <= 1'b0;
            fail_adr_o <= '0;
            fail_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        word       <= '0;
                        seed_q     <= seed_i;
                        mis_q      <= 1'b0;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        pass_o     <= 1'b0;
                        timeout_o  <= 1'b0;
                        fail_adr_o <= '0;
                        fail_dat_o <= '0;
                    end
                end
                ST_WR_REQ, ST_RD_REQ: begin
                    if (port_tmo) begin
                        timeout_o  <= 1'b1;
                        fail_adr_o <= word;
                        fail_dat_o <= 32'h0;
                    end else if (rd_mismatch) begin
                        mis_q      <= 1'b1;
                        fail_adr_o <= word;
                        fail_dat_o <= port_rdata;
                    end
                end
                // Word wraps to 0 after the last index, ready for the read phase.
                ST_WR_GAP, ST_RD_GAP: word <= word + 1'b1;
                ST_DONE: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    pass_o <= ~(mis_q | timeout_o);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_bist_master.sv
module tb_wb_ram_bist_master;

    localparam int AW = 4;
    localparam int TW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [31:0]     seed = 32'h0;
    logic            cyc, stb, we;
    logic [3:0]      sel;
    logic [AW+1:0]   adr;
    logic [31:0]     dat_w;
    logic            ack;
    logic [31:0]     dat_r;
    logic            busy, done, pass, tmo;
    logic [AW-1:0]   fail_adr;
    logic [31:0]     fail_dat;

    always #5 clk = ~clk;

    wb_ram_bist_master #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .seed_i     (seed),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_w),
        .wbm_ack_i  (ack),
        .wbm_dat_i  (dat_r),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .timeout_o  (tmo),
        .fail_adr_o (fail_adr),
        .fail_dat_o (fail_dat)
    );

    // Behavioural RAM slave: wait states, read bit-flip, write never-acked.
    logic [31:0]   mem [16];
    int            waits = 0;
    int            wcnt = 0;
    logic          flip_en = 1'b0;
    logic [3:0]    flip_word = 4'd0;
    logic          noack_en = 1'b0;
    logic [3:0]    noack_word = 4'd0;
    logic          block;

    assign block = noack_en && we && (adr[5:2] == noack_word);
    assign ack   = cyc && stb && !block && (wcnt == waits);
    assign dat_r = mem[adr[5:2]] ^ ((flip_en && !we && adr[5:2] == flip_word) ? 32'h1 : 32'h0);

    always @(posedge clk) begin
        if (cyc && stb && !ack) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
        if (ack && we) mem[adr[5:2]] <= dat_w;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus monitor state, cleared by clr_mon before each test.
    int          accesses, rd6, sel_bad, dat_bad, run, max_run, exp_run, run_bad, low, gap_bad;
    logic [31:0] exp_seed;

    task automatic clr_mon(input int er, input logic [31:0] s);
        accesses = 0; rd6 = 0; sel_bad = 0; dat_bad = 0; run = 0; max_run = 0;
        exp_run = er; run_bad = 0; low = 0; gap_bad = 0; exp_seed = s;
    endtask

    task automatic sample();
        if ((cyc && sel != 4'hF) || (!cyc && sel != 4'h0)) sel_bad++;
        if (cyc && stb && ack) begin
            accesses++;
            if (!we && adr == 6'd24) rd6++;
            if (we && dat_w != (exp_seed ^ {28'h0, adr[5:2]})) dat_bad++;
        end
        if (stb) begin
            if (low > 0 && low != 1) gap_bad++;
            low = 0;
            run++;
        end else begin
            if (run > 0) begin
                if (run > max_run) max_run = run;
                if (exp_run != 0 && run != exp_run) run_bad++;
            end
            run = 0;
            if (busy) low++;
            else      low = 0;
        end
    endtask

    // Pulses start across one rising edge; returns #1 after that edge.
    task automatic kick(input logic [31:0] s);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Monitors until done_o (or budget); n = edges after the start edge.
    task automatic run_test(input int budget, input int glitch_at, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            sample();
            if (done || n >= budget) break;
            @(posedge clk);
            n++;
            #1 start = (glitch_at != 0 && n == glitch_at);
        end
        start = 1'b0;
    endtask

    int n;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        #12;
        chk("reset_outputs", {31'h0, |{cyc, stb, we, sel, adr, dat_w, busy, done, pass, tmo, fail_adr, fail_dat}}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Zero-wait full pass.
        clr_mon(1, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        run_test(2000, 0, n);
        chk("zw_cycles", n, 65);
        chk("zw_pass", {done, pass, tmo}, 3'b110);
        chk("zw_accesses", accesses, 32);
        chk("zw_runs", run_bad, 0);
        chk("zw_gaps", gap_bad, 0);
        chk("zw_wdata", dat_bad, 0);
        chk("zw_mem15", mem[15], 32'hA5A5_000F);

        // Three wait states.
        waits = 3;
        clr_mon(4, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        run_test(2000, 0, n);
        chk("ws_cycles", n, 161);
        chk("ws_pass", {done, pass, tmo}, 3'b110);
        chk("ws_max_run", max_run, 4);
        chk("ws_runs", run_bad, 0);
        chk("ws_gaps", gap_bad, 0);
        chk("ws_sel", sel_bad, 0);
        waits = 0;

        // Read bit-flip on word 5.
        flip_en = 1'b1; flip_word = 4'd5;
        clr_mon(1, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        run_test(2000, 0, n);
        chk("flip_flags", {done, pass, tmo}, 3'b100);
        chk("flip_adr", fail_adr, 5);
        chk("flip_dat", fail_dat, 32'hA5A5_0004);
        chk("flip_no_word6", rd6, 0);
        chk("flip_accesses", accesses, 22);
        flip_en = 1'b0;

        // Word 2 write never acked.
        noack_en = 1'b1; noack_word = 4'd2;
        clr_mon(0, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        run_test(2000, 0, n);
        chk("tmo_stb_run", max_run, 63);
        chk("tmo_flags", {done, pass, tmo}, 3'b101);
        chk("tmo_adr", fail_adr, 2);
        chk("tmo_dat", fail_dat, 32'h0);
        chk("tmo_bus_idle", {cyc, stb}, 2'b00);
        noack_en = 1'b0;

        // Start pulsed mid-test is ignored.
        clr_mon(1, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        run_test(2000, 20, n);
        chk("glitch_cycles", n, 65);
        chk("glitch_pass", {done, pass, tmo}, 3'b110);

        // Reset while writing word 7.
        clr_mon(1, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        n = 0;
        while (!(cyc && we && adr == 6'd28) && n < 200) begin
            @(posedge clk); #1 n++;
        end
        chk("rst_reached_w7", {31'h0, n < 200}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {31'h0, |{cyc, stb, we, sel, adr, dat_w, busy, done, pass, tmo, fail_adr, fail_dat}}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Failing run, then a second start with a new seed.
        flip_en = 1'b1; flip_word = 4'd5;
        clr_mon(1, 32'hA5A5_0000);
        kick(32'hA5A5_0000);
        run_test(2000, 0, n);
        chk("pre_fail_adr", fail_adr, 5);
        flip_en = 1'b0;
        clr_mon(1, 32'h1234_5678);
        kick(32'h1234_5678);
        chk("restart_cleared", {done, pass, tmo, fail_adr, fail_dat}, 39'h0);
        run_test(2000, 0, n);
        chk("restart_pass", {done, pass, tmo}, 3'b110);
        chk("restart_mem3", mem[3], 32'h1234_567B);
        chk("restart_wdata", dat_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
